// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - default reset PC, NOP and HALT instruction encodings
//   - instruction memory window, expressed as word indices (byte address >> 2)
//   - fetch FSM state encoding
//   - small PC arithmetic helper
package instr_fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_NOP_INSTR  = 32'h0000_0000;

  // Legal instruction memory window, inclusive, in words.
  localparam logic [29:0] INSTR_MEM_LO = 30'd0;
  localparam logic [29:0] INSTR_MEM_HI = 30'd1023;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^32 with no carry out.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_pc_sel.sv
// Combinational next-PC selection and fetch address check.
// Ports:
//   i_pc          current program counter (byte address)
//   i_redirect    branch/jump taken; highest priority
//   i_redirect_pc redirect target
//   i_hold        keep the current PC (stall or halt capture)
//   o_next_pc     selected next PC: redirect target, current PC, or PC+4
//   o_addr_fault  current PC is misaligned or outside the instruction memory
module fetch_pc_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_hold,
  output logic [31:0] o_next_pc,
  output logic        o_addr_fault
);

  logic [29:0] w_word_off;
  logic        w_misaligned;
  logic        w_out_of_range;

  // Offsetting by the window base turns the two-sided range test into one
  // unsigned compare: words below the base wrap around to huge offsets.
  assign w_word_off     = i_pc[31:2] - INSTR_MEM_LO;
  assign w_misaligned   = (i_pc[1:0] != 2'b00);
  assign w_out_of_range = (w_word_off > (INSTR_MEM_HI - INSTR_MEM_LO));
  assign o_addr_fault   = w_misaligned | w_out_of_range;

  always_comb begin
    o_next_pc = pcPlus4(i_pc);
    if (i_redirect) begin
      o_next_pc = i_redirect_pc;
    end else if (i_hold) begin
      o_next_pc = i_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID pipeline register.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   pc            byte address to instruction memory
//   instr         word returned by memory for pc
//   stall         hold PC and IF/ID
//   redirect      taken branch/jump, with target redirect_pc
//   if_id_pc      PC of the captured instruction
//   if_id_pc4     if_id_pc + 4
//   if_id_instr   captured instruction word
//   if_id_valid   IF/ID holds a real instruction
//   halted        fetch stopped by a halt word or an address fault
//   fault         sticky address fault flag
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HALT_INSTR = DEF_HALT_INSTR,
  parameter logic [31:0] NOP_INSTR  = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_if_id_pc;
  logic [31:0]  r_if_id_pc4;
  logic [31:0]  r_if_id_instr;
  logic         r_if_id_valid;
  logic         r_halted;
  logic         r_fault;

  fetch_state_e w_next_state;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_if_id_pc_next;
  logic [31:0]  w_if_id_pc4_next;
  logic [31:0]  w_if_id_instr_next;
  logic         w_if_id_valid_next;
  logic         w_halted_next;
  logic         w_fault_next;

  logic         w_is_halt;
  logic         w_hold;
  logic [31:0]  w_sel_pc;
  logic         w_addr_fault;

  // A captured halt word freezes the PC, so it is treated like a stall for
  // the next-PC mux; redirect still overrides it inside the selector.
  assign w_is_halt = (instr == HALT_INSTR);
  assign w_hold    = stall | w_is_halt;

  fetch_pc_sel u_pc_sel (
    .i_pc          (r_pc),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_hold        (w_hold),
    .o_next_pc     (w_sel_pc),
    .o_addr_fault  (w_addr_fault)
  );

  // Next-state and next-register logic. Everything holds by default; only
  // FETCH moves the PC. A bad PC beats redirect and stall because the word
  // on instr cannot be trusted and the fault must be reported regardless.
  always_comb begin
    w_next_state       = r_state;
    w_pc_next          = r_pc;
    w_if_id_pc_next    = r_if_id_pc;
    w_if_id_pc4_next   = r_if_id_pc4;
    w_if_id_instr_next = r_if_id_instr;
    w_if_id_valid_next = r_if_id_valid;
    w_halted_next      = r_halted;
    w_fault_next       = r_fault;

    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_FETCH;
      end

      ST_FETCH: begin
        if (w_addr_fault) begin
          w_fault_next       = 1'b1;
          w_halted_next      = 1'b1;
          w_if_id_valid_next = 1'b0;
          w_next_state       = ST_HALTED;
        end else if (redirect) begin
          w_pc_next          = w_sel_pc;
          w_if_id_instr_next = NOP_INSTR;
          w_if_id_valid_next = 1'b0;
        end else if (!stall) begin
          w_pc_next          = w_sel_pc;
          w_if_id_pc_next    = r_pc;
          w_if_id_pc4_next   = pcPlus4(r_pc);
          w_if_id_instr_next = instr;
          w_if_id_valid_next = 1'b1;
          if (w_is_halt) begin
            w_halted_next = 1'b1;
            w_next_state  = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        w_if_id_valid_next = 1'b0;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State and pipeline registers, all cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'h0;
      r_if_id_pc4   <= 32'h0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_pc_next;
      r_if_id_pc    <= w_if_id_pc_next;
      r_if_id_pc4   <= w_if_id_pc4_next;
      r_if_id_instr <= w_if_id_instr_next;
      r_if_id_valid <= w_if_id_valid_next;
      r_halted      <= w_halted_next;
      r_fault       <= w_fault_next;
    end
  end

  assign pc          = r_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign halted      = r_halted;
  assign fault       = r_fault;

endmodule
